// File: rtl/tt_ctrl_seq_if.sv
// Request port of the TinyTapeout mux-control sequencer: a valid/ready
// request carrying the target select address and the enable value to
// apply once the remote counter has been stepped there, plus a one-cycle
// completion pulse.
interface tt_ctrl_seq_if #(
    parameter int SEL_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_addr;
    logic             req_ena;
    logic             done;

    // Requester side: issues requests, observes ready and completion.
    modport master (
        output req_valid,
        output req_addr,
        output req_ena,
        input  req_ready,
        input  done
    );

    // Sequencer side: accepts requests, reports ready and completion.
    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_ena,
        output req_ready,
        output done
    );
endinterface

// File: rtl/tt_ctrl_seq.sv
// Sequencer for the TinyTapeout mux controller's three-wire control port.
// It keeps a shadow of the remote 10-bit ripple select counter. It steps
// that counter to a requested address, counting forward when it can and
// resetting first only when the target lies behind the current value.
// Finally it applies the requested enable. Every ctrl_* output is a
// flop with no logic after it, so the counter clock cannot glitch.
module tt_ctrl_seq #(
    parameter int SEL_W   = 10,
    parameter int PULSE_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    tt_ctrl_seq_if.slave     req,
    output logic [SEL_W-1:0] cur_addr,
    output logic             ctrl_sel_rst_n,
    output logic             ctrl_sel_inc,
    output logic             ctrl_ena
);

    localparam int TW = $clog2(PULSE_W + 1);

    // Every phase lasts PULSE_W cycles: load PULSE_W-1 on entry, leave at 0.
    // INIT lasts one extra cycle, because the counter reset is released on
    // the first edge and PULSE_W cycles of recovery follow it.
    localparam logic [TW-1:0]    TMR_PHASE = TW'(PULSE_W - 1);
    localparam logic [TW-1:0]    TMR_INIT  = TW'(PULSE_W);
    localparam logic [TW-1:0]    TMR_ONE   = TW'(1);
    localparam logic [TW-1:0]    TMR_ZERO  = TW'(0);
    localparam logic [SEL_W-1:0] ADDR_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] ADDR_ZERO = SEL_W'(0);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ENA_OFF = 3'd2,
        ST_RST_LO  = 3'd3,
        ST_RST_REC = 3'd4,
        ST_INC_HI  = 3'd5,
        ST_INC_LO  = 3'd6,
        ST_SETTLE  = 3'd7
    } state_t;

    state_t           state_r;
    logic [TW-1:0]    tmr_r;
    logic [SEL_W-1:0] n_r;          // increment pulses still to issue
    logic             rst_pend_r;   // target behind shadow: reset first
    logic             ena_r;        // enable value applied on completion
    logic             req_ready_r;
    logic             done_r;

    logic             accept_s;
    logic             r_s;
    logic [SEL_W-1:0] n_s;
    logic             tmr_done_s;

    assign req.req_ready = req_ready_r;
    assign req.done      = done_r;

    // Accept strobe, reset decision and pulse count for an incoming request.
    always_comb begin
        accept_s   = req.req_valid & req_ready_r;
        tmr_done_s = (tmr_r == TMR_ZERO);
        if (req.req_addr >= cur_addr) begin
            r_s = 1'b0;
            n_s = req.req_addr - cur_addr;
        end else begin
            r_s = 1'b1;
            n_s = req.req_addr;
        end
    end

    // Sequencer FSM: walks the phases and drives every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_INIT;
            tmr_r          <= TMR_INIT;
            n_r            <= ADDR_ZERO;
            rst_pend_r     <= 1'b0;
            ena_r          <= 1'b0;
            req_ready_r    <= 1'b0;
            done_r         <= 1'b0;
            cur_addr       <= ADDR_ZERO;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    ctrl_sel_rst_n <= 1'b1;
                    if (tmr_done_s) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        ena_r       <= req.req_ena;
                        rst_pend_r  <= r_s;
                        n_r         <= n_s;
                        ctrl_ena    <= 1'b0;
                        req_ready_r <= 1'b0;
                        tmr_r       <= TMR_PHASE;
                        state_r     <= ST_ENA_OFF;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_ENA_OFF: begin
                    if (!tmr_done_s) begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end else if (rst_pend_r) begin
                        ctrl_sel_rst_n <= 1'b0;
                        tmr_r          <= TMR_PHASE;
                        state_r        <= ST_RST_LO;
                    end else if (n_r != ADDR_ZERO) begin
                        ctrl_sel_inc <= 1'b1;
                        cur_addr     <= cur_addr + ADDR_ONE;
                        n_r          <= n_r - ADDR_ONE;
                        tmr_r        <= TMR_PHASE;
                        state_r      <= ST_INC_HI;
                    end else begin
                        tmr_r   <= TMR_PHASE;
                        state_r <= ST_SETTLE;
                    end
                end
                ST_RST_LO: begin
                    if (tmr_done_s) begin
                        ctrl_sel_rst_n <= 1'b1;
                        cur_addr       <= ADDR_ZERO;
                        tmr_r          <= TMR_PHASE;
                        state_r        <= ST_RST_REC;
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                ST_RST_REC: begin
                    if (!tmr_done_s) begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end else if (n_r != ADDR_ZERO) begin
                        ctrl_sel_inc <= 1'b1;
                        cur_addr     <= cur_addr + ADDR_ONE;
                        n_r          <= n_r - ADDR_ONE;
                        tmr_r        <= TMR_PHASE;
                        state_r      <= ST_INC_HI;
                    end else begin
                        tmr_r   <= TMR_PHASE;
                        state_r <= ST_SETTLE;
                    end
                end
                ST_INC_HI: begin
                    if (tmr_done_s) begin
                        ctrl_sel_inc <= 1'b0;
                        tmr_r        <= TMR_PHASE;
                        state_r      <= ST_INC_LO;
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                ST_INC_LO: begin
                    if (!tmr_done_s) begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end else if (n_r != ADDR_ZERO) begin
                        ctrl_sel_inc <= 1'b1;
                        cur_addr     <= cur_addr + ADDR_ONE;
                        n_r          <= n_r - ADDR_ONE;
                        tmr_r        <= TMR_PHASE;
                        state_r      <= ST_INC_HI;
                    end else begin
                        tmr_r   <= TMR_PHASE;
                        state_r <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_done_s) begin
                        ctrl_ena    <= ena_r;
                        done_r      <= 1'b1;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        tmr_r <= tmr_r - TMR_ONE;
                    end
                end
                default: begin
                    state_r        <= ST_INIT;
                    tmr_r          <= TMR_INIT;
                    req_ready_r    <= 1'b0;
                    cur_addr       <= ADDR_ZERO;
                    ctrl_sel_rst_n <= 1'b0;
                    ctrl_sel_inc   <= 1'b0;
                    ctrl_ena       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Directed bench for tt_ctrl_seq: requests with hand-computed latencies,
// pulse counts and shadow values. The bench keeps its own model of the
// remote ripple counter, driven only by the control wires.
module tb_tt_ctrl_seq;

    localparam int SEL_W   = 10;
    localparam int PULSE_W = 2;

    logic             clk;
    logic             rst_n;
    logic [SEL_W-1:0] cur_addr;
    logic             ctrl_sel_rst_n;
    logic             ctrl_sel_inc;
    logic             ctrl_ena;

    int n_chk;
    int n_fail;

    tt_ctrl_seq_if #(.SEL_W(SEL_W)) req_if ();

    tt_ctrl_seq #(.SEL_W(SEL_W), .PULSE_W(PULSE_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req_if),
        .cur_addr       (cur_addr),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remote ripple select counter model, fed only by the control wires.
    logic [SEL_W-1:0] model_cnt;
    always @(posedge ctrl_sel_inc or negedge ctrl_sel_rst_n) begin
        if (!ctrl_sel_rst_n) model_cnt <= '0;
        else                 model_cnt <= model_cnt + 10'd1;
    end

    // Running totals of increment pulses and counter-reset assertions.
    int inc_total = 0;
    int rst_total = 0;
    always @(posedge ctrl_sel_inc)    inc_total <= inc_total + 1;
    always @(negedge ctrl_sel_rst_n)  rst_total <= rst_total + 1;

    // Shortest high/low widths of the increment clock and shortest counter-reset low width.
    int   min_hi  = 1000000;
    int   min_lo  = 1000000;
    int   min_rlo = 1000000;
    int   run_inc = 0;
    int   run_rst = 0;
    logic prev_inc = 1'b0;
    logic prev_rst = 1'b0;
    logic seen_hi  = 1'b0;
    always @(negedge clk) begin
        if (ctrl_sel_inc === prev_inc) begin
            run_inc <= run_inc + 1;
        end else begin
            if (prev_inc) begin
                if (run_inc < min_hi) min_hi <= run_inc;
                seen_hi <= 1'b1;
            end else if (seen_hi) begin
                if (run_inc < min_lo) min_lo <= run_inc;
            end
            run_inc <= 1;
        end
        prev_inc <= ctrl_sel_inc;
        if (ctrl_sel_rst_n === prev_rst) begin
            run_rst <= run_rst + 1;
        end else begin
            if (!prev_rst && run_rst < min_rlo) min_rlo <= run_rst;
            run_rst <= 1;
        end
        prev_rst <= ctrl_sel_rst_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for ready, issue one request, and measure latency, pulses and resets.
    task automatic do_req(input logic [SEL_W-1:0] addr, input logic ena,
                          output int lat, output int ninc, output int nrst);
        int w;
        int ib;
        int rb;
        w = 0;
        while (req_if.req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_req", 32'(req_if.req_ready), 32'd1);
        req_if.req_valid = 1'b1;
        req_if.req_addr  = addr;
        req_if.req_ena   = ena;
        ib = inc_total;
        rb = rst_total;
        @(posedge clk);
        #1;
        req_if.req_valid = 1'b0;
        check("ena_off_after_accept", 32'(ctrl_ena), 32'd0);
        check("ready_low_after_accept", 32'(req_if.req_ready), 32'd0);
        lat = 0;
        while (lat < 5000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (req_if.done === 1'b1) break;
        end
        ninc = inc_total - ib;
        nrst = rst_total - rb;
        check("ready_with_done", 32'(req_if.req_ready), 32'd1);
    endtask

    int lat;
    int ninc;
    int nrst;
    int ib;
    int w;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        req_if.req_valid = 1'b0;
        req_if.req_addr  = '0;
        req_if.req_ena   = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset, then the INIT recovery window.
        repeat (3) @(negedge clk);
        check("rst_sel_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        check("rst_ena", 32'(ctrl_ena), 32'd0);
        check("rst_ready", 32'(req_if.req_ready), 32'd0);
        check("rst_done", 32'(req_if.done), 32'd0);
        check("rst_cur_addr", 32'(cur_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_sel_rst_n_rise", 32'(ctrl_sel_rst_n), 32'd1);
        check("init_ready_c1", 32'(req_if.req_ready), 32'd0);
        @(negedge clk);
        check("init_ready_c2", 32'(req_if.req_ready), 32'd0);
        @(negedge clk);
        check("init_ready_c3", 32'(req_if.req_ready), 32'd1);

        // 0 -> 3: forward only, 3 pulses, L = 2*(2+6) = 16.
        do_req(10'd3, 1'b1, lat, ninc, nrst);
        check("a3_latency", 32'(lat), 32'd16);
        check("a3_inc_pulses", 32'(ninc), 32'd3);
        check("a3_rst_pulses", 32'(nrst), 32'd0);
        check("a3_cur_addr", 32'(cur_addr), 32'd3);
        check("a3_model", 32'(model_cnt), 32'd3);
        check("a3_ena", 32'(ctrl_ena), 32'd1);

        // 3 -> 1: reset path, 1 pulse, L = 2*(2+2+2) = 12.
        do_req(10'd1, 1'b1, lat, ninc, nrst);
        check("a1_latency", 32'(lat), 32'd12);
        check("a1_inc_pulses", 32'(ninc), 32'd1);
        check("a1_rst_pulses", 32'(nrst), 32'd1);
        check("a1_cur_addr", 32'(cur_addr), 32'd1);
        check("a1_model", 32'(model_cnt), 32'd1);

        // 1 -> 1 with ena=0: no pulses, L = 4, enable drops.
        do_req(10'd1, 1'b0, lat, ninc, nrst);
        check("same_latency", 32'(lat), 32'd4);
        check("same_inc_pulses", 32'(ninc), 32'd0);
        check("same_rst_pulses", 32'(nrst), 32'd0);
        check("same_ena", 32'(ctrl_ena), 32'd0);
        check("same_cur_addr", 32'(cur_addr), 32'd1);

        // 1 -> 0: reset path with n = 0, L = 8.
        do_req(10'd0, 1'b1, lat, ninc, nrst);
        check("z1_latency", 32'(lat), 32'd8);
        check("z1_rst_pulses", 32'(nrst), 32'd1);
        check("z1_cur_addr", 32'(cur_addr), 32'd0);

        // 0 -> 1023: full-range count, L = 2*(2+2046) = 4096.
        do_req(10'd1023, 1'b1, lat, ninc, nrst);
        check("max_latency", 32'(lat), 32'd4096);
        check("max_inc_pulses", 32'(ninc), 32'd1023);
        check("max_rst_pulses", 32'(nrst), 32'd0);
        check("max_cur_addr", 32'(cur_addr), 32'd1023);
        check("max_model", 32'(model_cnt), 32'd1023);

        // 1023 -> 0: reset path, n = 0, L = 8.
        do_req(10'd0, 1'b0, lat, ninc, nrst);
        check("z2_latency", 32'(lat), 32'd8);
        check("z2_inc_pulses", 32'(ninc), 32'd0);
        check("z2_rst_pulses", 32'(nrst), 32'd1);
        check("z2_cur_addr", 32'(cur_addr), 32'd0);
        check("z2_model", 32'(model_cnt), 32'd0);

        // 0 -> 5, with reset asserted during the low phase of pulse 3.
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_addr  = 10'd5;
        req_if.req_ena   = 1'b1;
        ib = inc_total;
        @(posedge clk);
        #1;
        req_if.req_valid = 1'b0;
        w = 0;
        while (!((inc_total - ib) == 3 && ctrl_sel_inc === 1'b0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("mid_reached_pulse3", 32'(inc_total - ib), 32'd3);
        check("mid_cur_before", 32'(cur_addr), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_sel_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        check("mid_inc", 32'(ctrl_sel_inc), 32'd0);
        check("mid_ena", 32'(ctrl_ena), 32'd0);
        check("mid_ready", 32'(req_if.req_ready), 32'd0);
        check("mid_cur_addr", 32'(cur_addr), 32'd0);
        check("mid_model", 32'(model_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 0 -> 2 after the reset: forward only, L = 2*(2+4) = 12.
        do_req(10'd2, 1'b1, lat, ninc, nrst);
        check("post_latency", 32'(lat), 32'd12);
        check("post_inc_pulses", 32'(ninc), 32'd2);
        check("post_rst_pulses", 32'(nrst), 32'd0);
        check("post_cur_addr", 32'(cur_addr), 32'd2);
        check("post_model", 32'(model_cnt), 32'd2);

        // Pulse widths seen across the whole run.
        check("min_inc_high", 32'(min_hi), 32'(PULSE_W));
        check("min_inc_low", 32'(min_lo), 32'(PULSE_W));
        check("min_rst_low", 32'(min_rlo), 32'(PULSE_W));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
